// File: rtl/xor_unit_if.sv
// xor_unit_if: operand/result bundle for the 64-bit XOR unit.
// The zf/sf/of members exist only when XOR_FLAGS_EN is defined.
interface xor_unit_if;
  logic signed [63:0] A;
  logic signed [63:0] B;
  logic               in_valid;
  logic signed [63:0] OUT;
  logic        [63:0] out_q;
  logic               out_valid;
`ifdef XOR_FLAGS_EN
  logic               zf;
  logic               sf;
  logic               of;
`endif

  // Requester side: drives operands, observes results.
  modport master (
    output A, B, in_valid,
    input  OUT, out_q, out_valid
`ifdef XOR_FLAGS_EN
    , input zf, sf, of
`endif
  );

  // Unit side: consumes operands, produces results.
  modport slave (
    input  A, B, in_valid,
    output OUT, out_q, out_valid
`ifdef XOR_FLAGS_EN
    , output zf, sf, of
`endif
  );
endinterface

// File: rtl/xor_unit.sv
// xor_unit: 64-bit bitwise XOR for the Y86 ALU.
// OUT is purely combinational; out_q/out_valid form a one-cycle capture stage.
// Optional Y86 condition codes (zf/sf/of) are built only with XOR_FLAGS_EN.
module xor_unit (
  input  logic      clk,
  input  logic      rst_n,
  xor_unit_if.slave bus
);
  localparam int unsigned W = 64;

  logic [W-1:0] xor_c;
  logic [W-1:0] out_q_r;
  logic         out_valid_r;

  // One independent XOR slice per bit; no carry chain between slices.
  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign xor_c[i] = bus.A[i] ^ bus.B[i];
  end

  assign bus.OUT       = $signed(xor_c);
  assign bus.out_q     = out_q_r;
  assign bus.out_valid = out_valid_r;

  // Capture stage: load on in_valid, valid is a per-capture pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        out_q_r <= xor_c;
      end
    end
  end

`ifdef XOR_FLAGS_EN
  logic zf_r;
  logic sf_r;
  logic of_r;

  assign bus.zf = zf_r;
  assign bus.sf = sf_r;
  assign bus.of = of_r;

  // Condition codes follow each capture; a logical op never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_r <= 1'b1;
      sf_r <= 1'b0;
      of_r <= 1'b0;
    end else if (bus.in_valid) begin
      zf_r <= (xor_c == W'(0));
      sf_r <= xor_c[W-1];
      of_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_xor_unit.sv
// tb_xor_unit: directed vector table, reset corner cases and random
// stimulus against a behavioural model for xor_unit.
module tb_xor_unit;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  xor_unit_if bus ();

  xor_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        iv;
    logic [63:0] exp_out;
    logic [63:0] exp_q;
    logic        exp_valid;
    logic        exp_zf;
    logic        exp_sf;
  } vec_t;

  // Reference XOR expressed as "set in either but not both".
  function automatic logic [63:0] ref_xor(input logic [63:0] a, input logic [63:0] b);
    return (a | b) & ~(a & b);
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic ezf, input logic esf);
`ifdef XOR_FLAGS_EN
    check1({name, ".zf"}, bus.zf, ezf);
    check1({name, ".sf"}, bus.sf, esf);
    check1({name, ".of"}, bus.of, 1'b0);
`else
    if (ezf === 1'bx && esf === 1'bx) $display("flag check skipped: %s", name);
`endif
  endtask

  vec_t        vecs[7];
  logic [63:0] m_q;
  logic        m_valid;
  logic        m_zf;
  logic        m_sf;
  logic [63:0] ra;
  logic [63:0] rb;
  logic        riv;

  initial begin
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{64'h7F, 64'h07, 1'b0, 64'h78, 64'h0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000, 1'b1,
                64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h1, 64'h1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b1,
                64'h0, 64'h0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{64'h8000000000000000, 64'h0, 1'b1,
                64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 1'b1,
                64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{64'h5, 64'h3, 1'b0, 64'h6, 64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b1};

    // Reset asserted, operands applied before any clock edge.
    rst_n = 1'b0;
    bus.A = 64'h7F;
    bus.B = 64'h07;
    bus.in_valid = 1'b0;
    #1;
    check64("noclk.OUT", bus.OUT, 64'h78);
    check64("rst.out_q", bus.out_q, 64'h0);
    check1("rst.out_valid", bus.out_valid, 1'b0);
    check_flags("rst", 1'b1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      bus.A = vecs[i].a;
      bus.B = vecs[i].b;
      bus.in_valid = vecs[i].iv;
      #1;
      check64($sformatf("vec%0d.OUT", i), bus.OUT, vecs[i].exp_out);
      @(posedge clk);
      #1;
      check64($sformatf("vec%0d.out_q", i), bus.out_q, vecs[i].exp_q);
      check1($sformatf("vec%0d.out_valid", i), bus.out_valid, vecs[i].exp_valid);
      check_flags($sformatf("vec%0d", i), vecs[i].exp_zf, vecs[i].exp_sf);
      @(negedge clk);
    end

    // Nonzero capture, then asynchronous reset between edges.
    bus.A = 64'hFF;
    bus.B = 64'h0F;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check64("pre_rst.out_q", bus.out_q, 64'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check64("async_rst.out_q", bus.out_q, 64'h0);
    check1("async_rst.out_valid", bus.out_valid, 1'b0);
    check_flags("async_rst", 1'b1, 1'b0);
    check64("async_rst.OUT", bus.OUT, 64'hF0);
    // Capture requested while reset held: reset wins.
    @(posedge clk);
    #1;
    check64("rst_wins.out_q", bus.out_q, 64'h0);
    check1("rst_wins.out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.A = 64'hAAAA0000AAAA0000;
    bus.B = 64'h5555000055550000;
    @(posedge clk);
    #1;
    check64("first_cap.out_q", bus.out_q, 64'hFFFF0000FFFF0000);
    check1("first_cap.out_valid", bus.out_valid, 1'b1);
    check_flags("first_cap", 1'b0, 1'b1);

    // Random traffic against the behavioural model.
    m_q = 64'hFFFF0000FFFF0000;
    m_valid = 1'b1;
    m_zf = 1'b0;
    m_sf = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      riv = 1'($urandom_range(0, 2) != 0);
      bus.A = ra;
      bus.B = rb;
      bus.in_valid = riv;
      #1;
      check64("rand.OUT", bus.OUT, ref_xor(ra, rb));
      if (riv) begin
        m_q = ref_xor(ra, rb);
        m_zf = (m_q == 64'h0);
        m_sf = m_q[63];
      end
      m_valid = riv;
      @(posedge clk);
      #1;
      check64("rand.out_q", bus.out_q, m_q);
      check1("rand.out_valid", bus.out_valid, m_valid);
      check_flags("rand", m_zf, m_sf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
